// File: rtl/adder_share_arbiter.sv
// One WIDTH-bit adder shared by two requesters with round-robin arbitration.
// Operands and results are registered; one operation is in flight at a time (IDLE -> EXEC -> RESP).
module adder_share_arbiter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ReqValid0,
    input  logic [WIDTH-1:0] ReqA0,
    input  logic [WIDTH-1:0] ReqB0,
    output logic             ReqReady0,
    input  logic             ReqValid1,
    input  logic [WIDTH-1:0] ReqA1,
    input  logic [WIDTH-1:0] ReqB1,
    output logic             ReqReady1,
    output logic             RspValid0,
    output logic             RspValid1,
    input  logic             RspReady,
    output logic [WIDTH-1:0] RspSum,
    output logic             RspCarry,
    output logic             RspOvf
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             ptr;
    logic             id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;

    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [WIDTH:0]   add_full;
    logic             add_ovf;

    // Grants only exist in IDLE; the pointer breaks ties when both requesters are valid.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !Reset) begin
            grant0 = ReqValid0 && (!ReqValid1 || !ptr);
            grant1 = ReqValid1 && (!ReqValid0 || ptr);
        end
    end

    assign accept = grant0 || grant1;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (RspReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign add_full = {1'b0, a_q} + {1'b0, b_q};
    assign add_ovf  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_full[WIDTH-1] != a_q[WIDTH-1]);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_q  <= grant1 ? ReqA1 : ReqA0;
                b_q  <= grant1 ? ReqB1 : ReqB0;
                id_q <= grant1;
                ptr  <= !grant1;
            end
            if (state == EXEC) begin
                sum_q   <= add_full[WIDTH-1:0];
                carry_q <= add_full[WIDTH];
                ovf_q   <= add_ovf;
            end
        end
    end

    assign ReqReady0 = grant0;
    assign ReqReady1 = grant1;
    assign RspValid0 = (state == RESP) && !id_q;
    assign RspValid1 = (state == RESP) && id_q;
    assign RspSum    = sum_q;
    assign RspCarry  = carry_q;
    assign RspOvf    = ovf_q;

endmodule
